tt_byte_strobe_loader: RTL and testbench
========================================

Name: tt_byte_strobe_loader

Overview:
- Host-side transmitter for the byte-strobe load interface of the RISC-V core top.
- The core samples an 8-bit value on its input byte bus when a one-cycle strobe is asserted, then needs idle time to process it.
- This block accepts whole words over a valid/ready handshake and serialises them LSB-byte-first onto that bus.
- Each byte gets a one-cycle strobe, followed by a programmable idle gap. The block sits in the bring-up harness and the on-chip loader path, driving the core's ui_in and uio_in[0].

Parameters:
- BYTES_PER_WORD, 4, bytes per accepted word; the in_data width is 8*BYTES_PER_WORD.
- GAP, 10, idle cycles after each strobe before the next strobe is allowed; 0 is legal.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  global enable; when low, all state is frozen.
- in_data  input  8*BYTES_PER_WORD  word to transmit; byte 0 = in_data[7:0].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_byte  output  8  byte presented to the core's input bus.
- out_strobe  output  1  one-cycle load strobe; drives core uio_in[0].
- busy  output  1  high whenever state is not IDLE.
- words_sent  output  CNT_W  count of fully transmitted words.

Behaviour:
- Reset values: state IDLE, out_byte 8'h00, out_strobe 0, in_ready 0 while rst_n is low, busy 0, words_sent 0, byte index 0, gap counter 0.
- Reset is asynchronous: asserting it mid-word aborts the transfer immediately and discards the latched word.
- FSM states are IDLE, SEND and WAIT. State, counters and out_byte update only on edges where ena=1.
- IDLE:
  - in_ready = ena.
  - On in_valid & in_ready: latch in_data, set byte index to 0, go to SEND.
- SEND:
  - out_strobe = (state==SEND) & ena, decoded from registered state.
  - Each byte therefore produces exactly one ena-high strobe cycle.
  - out_byte is registered and loaded with the current byte on the edge that enters SEND, so it is stable during the strobe.
  - Exit with GAP>0: go to WAIT and load the gap counter with GAP.
  - Exit with GAP=0: go to SEND for the next byte, or to IDLE if this was the last byte.
- WAIT:
  - Decrement the gap counter on each ena-high edge.
  - When the counter reads 1, go to SEND for the next byte, or to IDLE if the last byte has been sent.
- Timing: the strobe-to-strobe spacing is GAP+1 ena-high cycles. Handshake at edge N puts the first strobe in cycle N+1.
- out_byte holds its last value between strobes and in IDLE; it is never cleared except by reset.
- words_sent increments on the edge that leaves the final WAIT (or the final SEND when GAP=0) and wraps modulo 2^CNT_W.
- Back-to-back words: in_ready is 0 in SEND and WAIT, and goes high in the first IDLE cycle. There is no bypass.
- ena low during SEND keeps state SEND with strobe 0. The strobe asserts once when ena returns, so no pulse is lost or duplicated.
- in_valid dropping without a handshake has no effect. in_data is only sampled at the handshake.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined:
  - After the last data byte and its gap, send one extra byte equal to the XOR of all data bytes, with a strobe and a GAP wait.
  - words_sent increments after the checksum byte's gap.
  - A word occupies (BYTES_PER_WORD+1)*(GAP+1) ena-high cycles.
- Undefined: no checksum byte; a word occupies BYTES_PER_WORD*(GAP+1) cycles and no XOR logic is present.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles -> out_strobe=0, out_byte=00, busy=0, words_sent=0. Release with ena=1 -> in_ready=1.
- Single word, GAP=10: in_data=32'h0B0A0908 -> strobes carry 08, 09, 0A, 0B, exactly 11 cycles apart, each strobe 1 cycle wide. words_sent becomes 1 after the last gap, then in_ready=1.
- Async reset mid-word: assert rst_n=0 during the WAIT after the second byte -> outputs return to reset values immediately. After release, no further strobes occur until a new handshake.
- ena stall: drop ena for 5 cycles while in SEND -> no strobe while ena=0, exactly one strobe after ena returns, and following spacing is still 11 ena-high cycles.
- GAP=0 build with 3 back-to-back valid words -> 4 consecutive strobe cycles per word, one IDLE cycle between words, words_sent=3.
- LOADER_CKSUM_EN build with in_data=32'h44332211 -> 5 strobes carrying 11, 22, 33, 44, 44 (XOR). Without the macro, only 4 strobes.

Source files
------------

// File: rtl/tt_byte_strobe_loader_if.sv
// Word handshake bundle for tt_byte_strobe_loader: the host drives data/valid,
// the loader answers with ready.
interface tt_byte_strobe_loader_if #(
  parameter int BYTES_PER_WORD = 4
);
  logic [8*BYTES_PER_WORD-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tt_byte_strobe_loader.sv
// Serialises handshaked words LSB-byte-first onto the core's byte bus: one strobe
// per byte, then GAP idle cycles. Define LOADER_CKSUM_EN to append an XOR checksum byte.
module tt_byte_strobe_loader #(
  parameter int BYTES_PER_WORD = 4,
  parameter int GAP            = 10,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  tt_byte_strobe_loader_if.slave in_if,
  output logic [7:0]            out_byte,
  output logic                  out_strobe,
  output logic                  busy,
  output logic [CNT_W-1:0]      words_sent
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
`ifdef LOADER_CKSUM_EN
  localparam int N_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int N_BYTES = BYTES_PER_WORD;
`endif
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        byte_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              step;
  logic [7:0]        byte_arr [2**IDX_W];

  // Byte lanes of the latched word; the checksum lane sits just past the data.
  always_comb begin : byte_select
    for (int i = 0; i < 2**IDX_W; i++) byte_arr[i] = 8'h00;
    for (int i = 0; i < BYTES_PER_WORD; i++) byte_arr[i] = word_q[8*i +: 8];
`ifdef LOADER_CKSUM_EN
    begin : cksum_lane
      logic [7:0] cksum;
      cksum = 8'h00;
      for (int i = 0; i < BYTES_PER_WORD; i++) cksum = cksum ^ word_q[8*i +: 8];
      byte_arr[BYTES_PER_WORD] = cksum;
    end
`endif
  end

  always_comb begin : next_state
    // NOTE: every signal this block drives gets a default first, so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    word_d  = word_q;
    byte_d  = out_byte;
    cnt_d   = words_sent;
    step    = 1'b0;
    idx_nxt = idx_q + IDX_W'(1);
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (in_if.in_valid) begin
            word_d  = in_if.in_data;
            idx_d   = '0;
            byte_d  = in_if.in_data[7:0];
            state_d = SEND;
          end
        end
        SEND: begin
          if (GAP > 0) begin
            state_d = WAIT;
            gap_d   = GAP_W'(GAP);
          end else begin
            step = 1'b1;
          end
        end
        WAIT: begin
          gap_d = gap_q - GAP_W'(1);
          step  = (gap_q == GAP_W'(1));
        end
        default: state_d = IDLE;
      endcase
      // Byte slot finished: present the next lane, or retire the word.
      if (step) begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = words_sent + CNT_W'(1);
        end else begin
          state_d = SEND;
          idx_d   = idx_nxt;
          byte_d  = byte_arr[idx_nxt];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      word_q     <= '0;
      out_byte   <= 8'h00;
      words_sent <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      word_q     <= word_d;
      out_byte   <= byte_d;
      words_sent <= cnt_d;
    end
  end

  // Strobe is gated by ena so a frozen SEND cycle never counts as a load.
  assign out_strobe     = (state_q == SEND) & ena;
  assign busy           = (state_q != IDLE);
  assign in_if.in_ready = rst_n & ena & (state_q == IDLE);

endmodule

// File: tb/tb_tt_byte_strobe_loader.sv
// Bench for tt_byte_strobe_loader: a GAP=10 and a GAP=0 instance share stimulus and are
// checked every cycle against a slot-position model; LOADER_CKSUM_EN adds the checksum byte.
module tb_tt_byte_strobe_loader;
  localparam int BPW = 4;
  localparam int CW  = 16;
  localparam int G0  = 10;
  localparam int G1  = 0;
`ifdef LOADER_CKSUM_EN
  localparam int NB = BPW + 1;
`else
  localparam int NB = BPW;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  logic          str0, str1, busy0, busy1;
  logic [7:0]    byte0, byte1;
  logic [CW-1:0] ws0, ws1;
  logic          rdy0, rdy1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_byte_strobe_loader_if #(.BYTES_PER_WORD(BPW)) bus0 ();
  tt_byte_strobe_loader_if #(.BYTES_PER_WORD(BPW)) bus1 ();
  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign rdy0 = bus0.in_ready;
  assign rdy1 = bus1.in_ready;

  tt_byte_strobe_loader #(.BYTES_PER_WORD(BPW), .GAP(G0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_if(bus0.slave),
    .out_byte(byte0), .out_strobe(str0), .busy(busy0), .words_sent(ws0)
  );
  tt_byte_strobe_loader #(.BYTES_PER_WORD(BPW), .GAP(G1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_if(bus1.slave),
    .out_byte(byte1), .out_strobe(str1), .busy(busy1), .words_sent(ws1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < BPW; k++) x = x ^ w[8*k +: 8];
    return x;
  endfunction

  // Model: a word is NB slots of GAP+1 ena-high cycles; the strobe is slot position 0.
  logic          mactive [2];
  int            mpos    [2];
  logic [7:0]    mout    [2];
  logic [CW-1:0] mcnt    [2];
  logic [7:0]    mbytes  [2][5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mactive[d] <= 1'b0;
        mpos[d]    <= 0;
        mout[d]    <= 8'h00;
        mcnt[d]    <= '0;
      end
    end else if (ena) begin
      for (int d = 0; d < 2; d++) begin
        int per;
        int np;
        per = gap_of(d) + 1;
        np  = mpos[d] + 1;
        if (!mactive[d]) begin
          if (in_valid) begin
            mactive[d] <= 1'b1;
            mpos[d]    <= 0;
            mout[d]    <= in_data[7:0];
            for (int k = 0; k < BPW; k++) mbytes[d][k] <= in_data[8*k +: 8];
            mbytes[d][BPW] <= xor_bytes(in_data);
          end
        end else if (np == NB * per) begin
          mactive[d] <= 1'b0;
          mcnt[d]    <= mcnt[d] + 1'b1;
        end else begin
          mpos[d] <= np;
          if (np % per == 0) mout[d] <= mbytes[d][np / per];
        end
      end
    end
  end

  int         log_cyc0 [$];
  int         log_cyc1 [$];
  logic [7:0] log_b0 [$];
  logic [7:0] log_b1 [$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int per;
      per = gap_of(d) + 1;
      check($sformatf("strobe[%0d]", d), 32'((d == 0) ? str0 : str1),
            32'(mactive[d] && ena && (mpos[d] % per == 0)));
      check($sformatf("busy[%0d]", d), 32'((d == 0) ? busy0 : busy1), 32'(mactive[d]));
      check($sformatf("out_byte[%0d]", d), 32'((d == 0) ? byte0 : byte1), 32'(mout[d]));
      check($sformatf("words_sent[%0d]", d), 32'((d == 0) ? ws0 : ws1), 32'(mcnt[d]));
      check($sformatf("in_ready[%0d]", d), 32'((d == 0) ? rdy0 : rdy1),
            32'(rst_n && ena && !mactive[d]));
    end
    if (str0) begin log_cyc0.push_back(cyc); log_b0.push_back(byte0); end
    if (str1) begin log_cyc1.push_back(cyc); log_b1.push_back(byte1); end
  end

  task automatic wait_ws(input int d, input logic [CW-1:0] target, input int budget);
    int k;
    k = 0;
    while ((((d == 0) ? ws0 : ws1) != target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_words_sent[%0d]", d), 32'((d == 0) ? ws0 : ws1), 32'(target));
  endtask

  task automatic send_word(input logic [31:0] w, output int hcyc);
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #2;
    in_valid = 1'b0;
    hcyc = cyc;
  endtask

  // Literal per-word expectations checked against the gap-10 strobe log.
  task automatic check_word0(input string tag, input int base, input int hcyc,
                             input logic [31:0] w, input logic [7:0] ck);
    check({tag, "_count"}, 32'(log_b0.size() - base), 32'(NB));
    if (log_b0.size() >= base + NB) begin
      check({tag, "_first_cycle"}, 32'(log_cyc0[base]), 32'(hcyc));
      for (int i = 0; i < NB; i++)
        check($sformatf("%s_byte%0d", tag, i), 32'(log_b0[base+i]),
              32'((i < BPW) ? w[8*i +: 8] : ck));
      for (int i = 1; i < NB; i++)
        check($sformatf("%s_spacing%0d", tag, i),
              32'(log_cyc0[base+i] - log_cyc0[base+i-1]), 32'(G0 + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int h;
    int k;
    logic [7:0] exp2 [5];
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

    ena = 1'b1;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_strobe", 32'(str0), 0);
    check("rst_byte", 32'(byte0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_words", 32'(ws0), 0);
    check("rst_ready", 32'(rdy0), 0);
    check("rst_ready_g0", 32'(rdy1), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy0), 1);

    // Single word, 08 09 0A 0B (checksum 00).
    base = log_b0.size();
    send_word(32'h0B0A0908, h);
    wait_ws(0, 1, 200);
    check("single_ready_after", 32'(rdy0), 1);
    check_word0("single", base, h, 32'h0B0A0908, 8'h00);
    wait_ws(1, 1, 50);

    // Async reset in the gap after the second byte.
    base = log_b0.size();
    send_word(32'hDEADBEEF, h);
    k = 0;
    while (log_b0.size() < base + 2 && k < 100) begin @(negedge clk); k++; end
    check("abort_two_strobes", 32'(log_b0.size() - base), 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobe", 32'(str0), 0);
    check("abort_byte", 32'(byte0), 0);
    check("abort_busy", 32'(busy0), 0);
    check("abort_words", 32'(ws0), 0);
    check("abort_ready", 32'(rdy0), 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    base = log_b0.size();
    repeat (60) @(negedge clk);
    check("abort_no_strobes", 32'(log_b0.size()), 32'(base));

    // ena dropped for 5 cycles while the first byte sits in SEND.
    base = log_b0.size();
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = 32'h8C7B6A59;
    @(posedge clk); #2;
    in_valid = 1'b0;
    ena = 1'b0;
    h = cyc;
    repeat (5) @(posedge clk);
    #2 ena = 1'b1;
    wait_ws(0, 1, 200);
    check_word0("stall", base, h + 5, 32'h8C7B6A59, 8'hC4);

    // GAP=0 instance: three back-to-back words with valid held high.
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    base = log_b1.size();
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = 32'h44332211;
    repeat (2 * (NB + 1) + 1) @(posedge clk);
    #2 in_valid = 1'b0;
    wait_ws(1, 3, 100);
    check("b2b_count", 32'(log_b1.size() - base), 32'(3 * NB));
    if (log_b1.size() >= base + 3 * NB) begin
      for (int w = 0; w < 3; w++) begin
        for (int i = 0; i < NB; i++)
          check($sformatf("b2b_w%0d_byte%0d", w, i), 32'(log_b1[base + w*NB + i]), 32'(exp2[i]));
        for (int i = 1; i < NB; i++)
          check($sformatf("b2b_w%0d_consec%0d", w, i),
                32'(log_cyc1[base + w*NB + i] - log_cyc1[base + w*NB + i - 1]), 1);
        if (w > 0)
          check($sformatf("b2b_idle_gap%0d", w),
                32'(log_cyc1[base + w*NB] - log_cyc1[base + w*NB - 1]), 2);
      end
    end
    wait_ws(0, 1, 200);

    // Randomised traffic: ena stalls, sporadic valid, rare async reset glitches.
    repeat (3000) begin
      @(posedge clk); #2;
      ena      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = $urandom();
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
